// File: rtl/sha256_msg_packer.sv
// ----------------------------------------------------------------------------
// sha256_msg_packer
//   Front end of the single-block SHA-256 core. It collects an AXI4-Stream
//   byte message, packs the bytes big-endian into fourteen 32-bit words and
//   appends the 0x80 pad byte. The packed block and its byte count are then
//   offered to the core on its parallel input channel. A frame longer than
//   MAX_BYTES is thrown away, and frame_err pulses for one cycle to report it.
//
// Handshakes: a transfer happens on a rising aclk edge where valid and ready
//   are both high. A source holds valid and its data stable until that edge.
//   Ready may change in any cycle. This holds on both interfaces
//   (s_axis_* and string_dv/string_ready).
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   s_axis_tdata [7:0]   message byte, first byte of the message first
//   s_axis_tvalid        byte valid
//   s_axis_tready        packer can take a byte (COLLECT or DISCARD)
//   s_axis_tlast         last byte of the message
//   string_w0..w13       packed block words; w0 holds bytes 0..3
//   string_size [7:0]    message length in bytes
//   string_dv            block valid, held until string_ready
//   string_ready         core idle; takes the block when string_dv is high
//   frame_err            one-cycle pulse: an oversize frame was dropped
// ----------------------------------------------------------------------------
module sha256_msg_packer #(
   parameter int MAX_BYTES = 52
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [31:0] string_w0,
   output logic [31:0] string_w1,
   output logic [31:0] string_w2,
   output logic [31:0] string_w3,
   output logic [31:0] string_w4,
   output logic [31:0] string_w5,
   output logic [31:0] string_w6,
   output logic [31:0] string_w7,
   output logic [31:0] string_w8,
   output logic [31:0] string_w9,
   output logic [31:0] string_w10,
   output logic [31:0] string_w11,
   output logic [31:0] string_w12,
   output logic [31:0] string_w13,
   output logic [7:0]  string_size,
   output logic        string_dv,
   input  logic        string_ready,
   output logic        frame_err
);

   localparam logic [5:0] MAX_B = 6'(MAX_BYTES);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DISCARD = 2'd1,
      OFFER   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;

   // Block image: one byte per entry. blk[n] is message byte n.
   logic [7:0]  blk [0:55];
   logic [5:0]  cnt;
   logic [5:0]  cnt_p1;
   logic [7:0]  size_r;
   logic        ferr_r;
   logic        accept;
   logic        oversize;

   assign s_axis_tready = aresetn && ((state == COLLECT) || (state == DISCARD));
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign cnt_p1        = cnt + 6'd1;
   assign oversize      = (cnt == MAX_B);

   // State register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= COLLECT;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         COLLECT: begin
            if (accept) begin
               if (oversize) begin
                  // An oversize byte that is also the last byte ends the frame here.
                  state_nx = s_axis_tlast ? COLLECT : DISCARD;
               end else if (s_axis_tlast) begin
                  state_nx = OFFER;
               end
            end
         end
         DISCARD: begin
            if (accept && s_axis_tlast) begin
               state_nx = COLLECT;
            end
         end
         OFFER: begin
            if (string_ready) begin
               state_nx = COLLECT;
            end
         end
         default: state_nx = COLLECT;
      endcase
   end

   // Datapath: byte store, count, size and error pulse
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < 56; i++) begin
            blk[i] <= 8'h00;
         end
         cnt    <= 6'd0;
         size_r <= 8'd0;
         ferr_r <= 1'b0;
      end else begin
         ferr_r <= 1'b0;
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (oversize) begin
                     for (int i = 0; i < 56; i++) begin
                        blk[i] <= 8'h00;
                     end
                     cnt    <= 6'd0;
                     ferr_r <= s_axis_tlast;
                  end else begin
                     blk[cnt] <= s_axis_tdata;
                     cnt      <= cnt_p1;
                     if (s_axis_tlast) begin
                        // The pad byte goes directly after the last message byte.
                        blk[cnt_p1] <= 8'h80;
                        size_r      <= {2'b00, cnt_p1};
                     end
                  end
               end
            end
            DISCARD: begin
               if (accept && s_axis_tlast) begin
                  for (int i = 0; i < 56; i++) begin
                     blk[i] <= 8'h00;
                  end
                  cnt    <= 6'd0;
                  ferr_r <= 1'b1;
               end
            end
            OFFER: begin
               if (string_ready) begin
                  for (int i = 0; i < 56; i++) begin
                     blk[i] <= 8'h00;
                  end
                  cnt    <= 6'd0;
                  size_r <= 8'd0;
               end
            end
            default: begin
               cnt <= 6'd0;
            end
         endcase
      end
   end

   assign string_dv   = (state == OFFER);
   assign string_size = size_r;
   assign frame_err   = ferr_r;

   assign string_w0  = {blk[0],  blk[1],  blk[2],  blk[3]};
   assign string_w1  = {blk[4],  blk[5],  blk[6],  blk[7]};
   assign string_w2  = {blk[8],  blk[9],  blk[10], blk[11]};
   assign string_w3  = {blk[12], blk[13], blk[14], blk[15]};
   assign string_w4  = {blk[16], blk[17], blk[18], blk[19]};
   assign string_w5  = {blk[20], blk[21], blk[22], blk[23]};
   assign string_w6  = {blk[24], blk[25], blk[26], blk[27]};
   assign string_w7  = {blk[28], blk[29], blk[30], blk[31]};
   assign string_w8  = {blk[32], blk[33], blk[34], blk[35]};
   assign string_w9  = {blk[36], blk[37], blk[38], blk[39]};
   assign string_w10 = {blk[40], blk[41], blk[42], blk[43]};
   assign string_w11 = {blk[44], blk[45], blk[46], blk[47]};
   assign string_w12 = {blk[48], blk[49], blk[50], blk[51]};
   assign string_w13 = {blk[52], blk[53], blk[54], blk[55]};

endmodule
